piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out shift register that takes an N-bit word through a valid/ready load handshake and emits it one bit per clock on `dout`, flagged by `dout_valid`. It is the transmit end of the team's serial-in/parallel-out shift register: a `shift_register` of the same `N` clocking in `dout` while `dout_valid` is high ends the word with the original value in its `data_out`. It supports back-to-back words with no idle cycle between them.

## Interface
- `N`, 32: word width in bits, ≥ 2.
- `MSB_FIRST`, 1: 1 = bit N-1 is sent first, 0 = bit 0 is sent first.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_data`  in  N  word to serialize; sampled only on handshake.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial data bit.
- `dout_valid`  out  1  `dout` carries a payload bit this cycle.
- `last`  out  1  current `dout` is the final bit of the word.
- `busy`  out  1  a word is being shifted (equals `dout_valid`).

## Operation
- States: IDLE, SHIFT. Registers: N-bit shift register `sr`, bit counter `cnt` of width $clog2(N).
- Handshake: a word is accepted on a rising edge where `load_valid && load_ready`. There is no other way to load.
- `load_ready` = (state == IDLE) || (state == SHIFT && cnt == N-1). It is combinational from state and `cnt`, and is 0 while `rst` is high.
- On accept: `sr` <= `load_data`, `cnt` <= 0, state <= SHIFT.
- In SHIFT:
  - `dout` = `sr[N-1]` when MSB_FIRST=1, otherwise `sr[0]`.
  - `dout_valid` = 1.
  - `last` = (`cnt` == N-1).
- Each SHIFT cycle without accept: `sr` shifts toward the output end (left when MSB_FIRST=1, right otherwise), zero-filled; `cnt` <= `cnt`+1.
- At `cnt` == N-1:
  - If accept happens the same edge, reload and stay in SHIFT with `cnt` = 0 (back-to-back).
  - Otherwise go to IDLE.
- In IDLE: `dout` = 0, `dout_valid` = 0, `last` = 0, `busy` = 0. `load_data` changes are ignored.
- `load_valid` high while `load_ready` = 0 (mid-word): ignored. The word in flight is not corrupted. The source must hold `load_valid` and `load_data` until accepted.
- Width rule: `cnt` never exceeds N-1; there is no wrap within a word. Counter width is max(1, $clog2(N)).

## Timing
- Reset: on any edge with `rst` = 1, state <= IDLE, `sr` <= 0, `cnt` <= 0. The cycle after reset, all outputs are 0 except `load_ready` = 1 (once `rst` is low).
- Reset mid-word aborts the word immediately. No partial completion, and `last` is not emitted.
- Latency:
  - Accept at edge k puts the first bit on `dout` in cycle k..k+1 (registered, valid right after edge k).
  - The final bit is valid after edge k+N-1.
  - `dout_valid` is high for exactly N consecutive cycles per word.
- Throughput: with `load_valid` held continuously high, `dout_valid` stays high indefinitely, at 1 bit/clock.
- `last` is high for exactly one cycle per word, coincident with the final bit.
- A downstream `shift_register` sampling `dout` on the same edges that advance this block captures bit i on edge k+1+i.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `load_valid` = 1.
  - Required: no accept.
  - After release: `dout_valid` = 0, `last` = 0, `load_ready` = 1.
- Single word, N=32, MSB_FIRST=1: load 32'hA5A5_F00D.
  - Required: `dout` over 32 valid cycles = 1010_0101_1010_0101_1111_0000_0000_1101.
  - `last` high only on cycle 32; then IDLE.
  - A chained `shift_register` shows `data_out` = 32'hA5A5_F00D.
- Back-to-back: `load_valid` held high with 32'hFFFF_0000 then 32'h0000_FFFF.
  - Required: 64 contiguous `dout_valid` cycles, no gap.
  - `load_ready` pulses exactly at cnt 31 of word 1.
- Load during shift: assert `load_valid` with 32'h0 at cnt = 5 of word 32'hFFFF_FFFF.
  - Required: word 1 still emits 32 ones.
  - 32'h0 is accepted at that word's final cycle.
- Reset mid-word: assert `rst` at cnt = 10.
  - Required: `dout_valid` = 0 the next cycle, `last` never asserted.
  - A subsequent load of 32'h1 serializes correctly (31 zeros then 1).
- N=8, MSB_FIRST=0: load 8'b1100_0001.
  - Required: `dout` sequence 1,0,0,0,0,0,1,1.
  - `last` on the 8th bit.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift register.
// Accepts an N-bit word on a valid/ready handshake and emits it one bit per
// clock on dout with dout_valid high. A new word can be accepted on the final
// bit of the current one, so back-to-back words leave no idle cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word in flight; load_ready high (outside reset)
// SHIFT | word in flight; dout carries bit cnt; ready only on final bit
module piso_serializer #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] load_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         dout,
    output logic         dout_valid,
    output logic         last,
    output logic         busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   sr;
    logic [CW-1:0]  cnt;
    logic           at_end;
    logic           accept;

    assign at_end = (cnt == CNT_LAST);

    // Ready only when idle or on the final bit; held low while reset is high
    // so nothing can be accepted on a reset edge.
    assign load_ready = !rst && ((state == IDLE) || ((state == SHIFT) && at_end));
    assign accept     = load_valid && load_ready;
    assign busy       = dout_valid;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and serial outputs.
    always_comb begin
        state_next = state;
        dout       = 1'b0;
        dout_valid = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                dout_valid = 1'b1;
                last       = at_end;
                dout       = MSB_FIRST ? sr[N-1] : sr[0];
                if (at_end && !accept) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit counter. The counter holds at N-1 when a word
    // ends without a reload, so it never wraps inside a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sr  <= load_data;
            cnt <= '0;
        end else if ((state == SHIFT) && !at_end) begin
            sr  <= MSB_FIRST ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: a 32-bit MSB-first instance and an 8-bit
// LSB-first instance, each checked every cycle against a queue-based model
// of the bits still owed, plus literal expectations for directed scenarios.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit MSB-first instance
    logic        rst_a, lv_a;
    logic [31:0] ld_a;
    logic        ready_a, dout_a, dv_a, last_a, busy_a;

    // 8-bit LSB-first instance
    logic        rst_b, lv_b;
    logic [7:0]  ld_b;
    logic        ready_b, dout_b, dv_b, last_b, busy_b;

    piso_serializer #(.N(32), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .load_data(ld_a), .load_valid(lv_a),
        .load_ready(ready_a), .dout(dout_a), .dout_valid(dv_a),
        .last(last_a), .busy(busy_a)
    );

    piso_serializer #(.N(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .load_data(ld_b), .load_valid(lv_b),
        .load_ready(ready_b), .dout(dout_b), .dout_valid(dv_b),
        .last(last_b), .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of bits still to be sent, front = bit on dout this cycle.
    bit          qa[$];
    bit          qb[$];
    logic [31:0] chain_a = '0;
    logic [7:0]  chain_b = '0;

    // Model update for the 32-bit instance plus a downstream SIPO register.
    always @(posedge clk) begin
        bit acc;
        if (rst_a) begin
            qa.delete();
        end else begin
            if (dv_a) chain_a = {chain_a[30:0], dout_a};
            acc = lv_a && (qa.size() <= 1);
            if (qa.size() > 0) void'(qa.pop_front());
            if (acc) for (int i = 0; i < 32; i++) qa.push_back(ld_a[31-i]);
        end
    end

    // Model update for the 8-bit instance plus a downstream SIPO register.
    always @(posedge clk) begin
        bit acc;
        if (rst_b) begin
            qb.delete();
        end else begin
            if (dv_b) chain_b = {dout_b, chain_b[7:1]};
            acc = lv_b && (qb.size() <= 1);
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc) for (int i = 0; i < 8; i++) qb.push_back(ld_b[i]);
        end
    end

    // Per-cycle comparison of {ready, valid, dout, last, busy} against the model.
    always @(negedge clk) begin
        logic [4:0] ea, eb;
        if (started) begin
            ea = {!rst_a && (qa.size() <= 1), qa.size() > 0,
                  (qa.size() > 0) ? qa[0] : 1'b0, qa.size() == 1, qa.size() > 0};
            eb = {!rst_b && (qb.size() <= 1), qb.size() > 0,
                  (qb.size() > 0) ? qb[0] : 1'b0, qb.size() == 1, qb.size() > 0};
            check("model_a", 64'({ready_a, dv_a, dout_a, last_a, busy_a}), 64'(ea));
            check("model_b", 64'({ready_b, dv_b, dout_b, last_b, busy_b}), 64'(eb));
        end
    end

    // Cycle log of the 32-bit instance for scenario analysis.
    bit lg_v[$], lg_d[$], lg_l[$], lg_r[$], lg_lv[$];
    bit lb_v[$], lb_d[$], lb_l[$];
    always @(negedge clk) begin
        lg_v.push_back(dv_a);  lg_d.push_back(dout_a); lg_l.push_back(last_a);
        lg_r.push_back(ready_a); lg_lv.push_back(lv_a);
        lb_v.push_back(dv_b);  lb_d.push_back(dout_b); lb_l.push_back(last_b);
    end

    task automatic clear_log();
        lg_v.delete(); lg_d.delete(); lg_l.delete(); lg_r.delete(); lg_lv.delete();
        lb_v.delete(); lb_d.delete(); lb_l.delete();
    endtask

    int          n_valid, n_last, last_at, n_rdy, first_rdy, first_acc, max_run;
    logic [63:0] bits64;

    task automatic analyze_a();
        int vi  = 0;
        int run = 0;
        n_last = 0; last_at = -1; n_rdy = 0; first_rdy = -1; first_acc = -1;
        max_run = 0; bits64 = '0;
        for (int i = 0; i < lg_v.size(); i++) begin
            if (lg_v[i]) begin
                bits64 = {bits64[62:0], lg_d[i]};
                if (lg_l[i]) begin
                    n_last++;
                    if (last_at < 0) last_at = vi;
                end
                if (lg_r[i]) begin
                    n_rdy++;
                    if (first_rdy < 0) first_rdy = vi;
                end
                if (lg_r[i] && lg_lv[i] && first_acc < 0) first_acc = vi;
                vi++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        n_valid = vi;
    endtask

    // Present a word, hold it until load_ready is seen, then release after the accepting edge.
    task automatic send_a(input logic [31:0] w);
        int n = 0;
        lv_a = 1'b1;
        ld_a = w;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_a && n < 200);
        if (!ready_a) begin
            checks++;
            failures++;
            $display("FAIL send_a_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        lv_a = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] vb;
        int vbi, nlb, lbat;

        rst_a = 1'b1; lv_a = 1'b1; ld_a = 32'h1234_5678;
        rst_b = 1'b1; lv_b = 1'b1; ld_b = 8'hFF;
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0; lv_a = 1'b0;
        rst_b = 1'b0; lv_b = 1'b0;
        @(negedge clk);
        check("rst_dout_valid", 64'(dv_a), 64'd0);
        check("rst_last", 64'(last_a), 64'd0);
        check("rst_load_ready", 64'(ready_a), 64'd1);
        check("rst_b_state", 64'({dv_b, last_b, ready_b}), 64'b001);

        // Single word MSB first
        @(posedge clk); #1;
        clear_log();
        send_a(32'hA5A5_F00D);
        wait_cycles(40);
        analyze_a();
        check("single_bits", bits64, 64'h0000_0000_A5A5_F00D);
        check("single_count", 64'(n_valid), 64'd32);
        check("single_last_n", 64'(n_last), 64'd1);
        check("single_last_at", 64'(last_at), 64'd31);
        check("single_chain", 64'(chain_a), 64'hA5A5_F00D);
        check("single_idle", 64'(dv_a), 64'd0);

        // Back-to-back with load_valid held
        clear_log();
        send_a(32'hFFFF_0000);
        send_a(32'h0000_FFFF);
        wait_cycles(40);
        analyze_a();
        check("b2b_run", 64'(max_run), 64'd64);
        check("b2b_count", 64'(n_valid), 64'd64);
        check("b2b_bits", bits64, 64'hFFFF_0000_0000_FFFF);
        check("b2b_ready_first", 64'(first_rdy), 64'd31);
        check("b2b_ready_n", 64'(n_rdy), 64'd2);
        check("b2b_last_n", 64'(n_last), 64'd2);
        check("b2b_chain", 64'(chain_a), 64'h0000_FFFF);

        // Load request mid-word
        clear_log();
        send_a(32'hFFFF_FFFF);
        wait_cycles(5);
        send_a(32'h0000_0000);
        wait_cycles(40);
        analyze_a();
        check("midload_bits", bits64, 64'hFFFF_FFFF_0000_0000);
        check("midload_accept_at", 64'(first_acc), 64'd31);
        check("midload_count", 64'(n_valid), 64'd64);

        // Reset mid-word at cnt 10
        clear_log();
        send_a(32'hDEAD_BEEF);
        wait_cycles(10);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(dv_a), 64'd0);
        analyze_a();
        check("abort_last_n", 64'(n_last), 64'd0);
        check("abort_count", 64'(n_valid), 64'd11);
        @(posedge clk); #1;
        clear_log();
        send_a(32'h0000_0001);
        wait_cycles(40);
        analyze_a();
        check("after_abort_bits", bits64, 64'h0000_0000_0000_0001);
        check("after_abort_last_at", 64'(last_at), 64'd31);
        check("after_abort_chain", 64'(chain_a), 64'h0000_0001);

        // 8-bit LSB-first instance
        clear_log();
        lv_b = 1'b1;
        ld_b = 8'b1100_0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_b && n < 50);
        check("b_ready_seen", 64'(ready_b), 64'd1);
        @(posedge clk); #1;
        lv_b = 1'b0;
        wait_cycles(12);
        vb = '0; vbi = 0; nlb = 0; lbat = -1;
        for (int i = 0; i < lb_v.size(); i++) begin
            if (lb_v[i]) begin
                if (vbi < 8) vb[vbi] = lb_d[i];
                if (lb_l[i]) begin
                    nlb++;
                    if (lbat < 0) lbat = vbi;
                end
                vbi++;
            end
        end
        check("lsb_bits", 64'(vb), 64'hC1);
        check("lsb_count", 64'(vbi), 64'd8);
        check("lsb_last_at", 64'(lbat), 64'd7);
        check("lsb_last_n", 64'(nlb), 64'd1);
        check("lsb_chain", 64'(chain_b), 64'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
